id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the 16-bit, 8-register pipelined MIPS core. It captures the two operands returned by the register file together with the decoded instruction fields and control bundle into the ID/EX pipeline register. It resolves data hazards by computing registered forwarding selects for the EX operand muxes, a write-through bypass for same-cycle writeback, and a load-use interlock that stalls IF/ID and injects a bubble.

## Interface
- Parameters:
  - `DW`, 16: data width.
  - `AW`, 3: register index width (8 registers, r0 reads as zero).
- Ports:
  - `clk`  in  1  single clock, all state on the rising edge.
  - `rst_n`  in  1  synchronous, active-low reset.
  - `id_valid`  in  1  IF/ID holds a real instruction.
  - `id_rs`, `id_rt`, `id_rd`  in  AW each  source and destination indices.
  - `id_imm`  in  DW  sign-extended immediate.
  - `id_ctrl`  in  8  control bundle `ctrl_t`: reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0].
  - `rf_rdata1`, `rf_rdata2`  in  DW  register-file read data for rs and rt.
  - `flush`  in  1  branch taken; kill the ID instruction.
  - `exm_valid`, `exm_reg_write`  in  1 each  EX/MEM holds a valid writer.
  - `exm_rd`  in  AW  EX/MEM destination.
  - `wb_reg_write`  in  1  writeback is writing this cycle.
  - `wb_rd`  in  AW  writeback destination.
  - `wb_data`  in  DW  writeback data.
  - `stall`  out  1  hold PC and IF/ID this cycle.
  - `ex_valid`  out  1  ID/EX holds a real instruction.
  - `ex_a`, `ex_b`, `ex_imm`  out  DW  captured operands and immediate.
  - `ex_rs`, `ex_rt`, `ex_rd`  out  AW  captured indices.
  - `ex_ctrl`  out  8  captured control.
  - `ex_fwd_a`, `ex_fwd_b`  out  2  EX mux select: 0 = `ex_a`/`ex_b`, 1 = EX/MEM result, 2 = MEM/WB result.
  - `stall_cnt`  out  16  saturating count of stall cycles.

## Operation
- Source match: a source matches a writer only if the index is nonzero, equal to the writer's rd, and the writer is valid with reg_write set. Index 0 never matches.
- Write-through: if `wb_reg_write` is set and `wb_rd` matches rs or rt, `wb_data` is captured instead of `rf_rdata`.
- Forwarding select is computed at capture time with nearest producer first:
  - ID/EX holds a matching writer: sel = 1 (the producer will be in EX/MEM next cycle).
  - Else EX/MEM holds a matching writer: sel = 2.
  - Else: sel = 0.
- Load-use hazard: ID/EX holds a valid mem_read instruction whose rd matches rs or rt of a valid ID instruction. Result:
  - `stall` = 1.
  - A bubble is loaded into ID/EX: `ex_valid` = 0 and `ex_ctrl` = 0; other fields don't-care but held.
  - A single stall cycle suffices. The following cycle the load sits in EX/MEM and yields sel = 2.
- Load priority, highest first: reset, `flush`, stall, normal load.
  - `flush` loads a bubble and forces `stall` = 0.
  - `id_valid` = 0 loads a bubble and `stall` = 0.
- `stall` is combinational from the current ID inputs and ID/EX contents.
- `stall_cnt` increments on each cycle with `stall` = 1 and saturates at 0xFFFF.

## Timing
- Latency is 1 cycle: fields present at edge N appear on `ex_*` after edge N.
- Reset clears all registered outputs to 0, including `ex_valid`, `ex_fwd_*` and `stall_cnt`. `stall` is 0 while `rst_n` = 0.
- Reset asserted mid-stall discards the bubble and the stalled instruction. Upstream holds IF/ID, so that instruction re-enters after reset.
- Flush and load-use in the same cycle: flush wins, and `stall_cnt` is not incremented.
- A writeback to r0 is never bypassed.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding as above. Only load-use hazards stall.
- Undefined: `ex_fwd_a` and `ex_fwd_b` are tied to 0, and the stall condition becomes "any source matches a writer in ID/EX or EX/MEM". This gives up to 2 stall cycles per dependency. Write-through bypass remains in both builds.

## Structure
- `mips16_pkg` holds:
  - the `ctrl_t` packed struct;
  - the `fwd_sel_t` enum (FWD_RF = 0, FWD_EXM = 1, FWD_WB = 2);
  - `DW` and `AW` constants;
  - `REG_ZERO` = 3'd0.
- Sub-module `id_hazard_unit`: a combinational block doing source-match comparisons, select generation and stall. It is shared with a future branch-compare stage.

## Test plan
- Back-to-back ALU ops: `add r1` followed immediately by `sub r2,r1,r3` gives `ex_fwd_a` = 1 and no stall. Next `or r4,r1,r1` gives `ex_fwd_a` = `ex_fwd_b` = 2.
- Load-use: `lw r5` followed by `add r6,r5,r2` gives exactly one `stall` cycle and a bubble with `ex_valid` = 0. The add then arrives with `ex_fwd_a` = 2, and `stall_cnt` = 1.
- Write-through: `wb_reg_write` = 1, `wb_rd` = 3, `wb_data` = 0xBEEF, `rf_rdata1` = 0x0000 and `id_rs` = 3 gives `ex_a` = 0xBEEF next cycle.
- r0 hazard: a writer to r0 followed by a reader of r0 gives no stall and sel = 0. A `wb_rd` = 0 bypass is ignored.
- Flush during load-use: `flush` = 1 gives `stall` = 0, `ex_valid` = 0 and `stall_cnt` unchanged.
- Build without `ID_EX_FWD_EN`: `add r1` then `sub r2,r1,r3` gives 2 stall cycles, then the sub is captured with `ex_a` = the bypassed `wb_data`. Reset mid-stall gives all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared types and constants for the 16-bit, 8-register pipelined MIPS core.
package mips16_pkg;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [AW-1:0] REG_ZERO = 3'd0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // r0 is hardwired to zero, so a write to it can never feed a reader.
  function automatic logic src_match(input logic [AW-1:0] idx,
                                     input logic          wr_valid,
                                     input logic          wr_en,
                                     input logic [AW-1:0] wr_rd);
    return (idx != REG_ZERO) && wr_valid && wr_en && (idx == wr_rd);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage signal bundle: decode inputs, downstream writer info, EX-side outputs.
interface id_ex_stage_if #(
  parameter int DW = mips16_pkg::DW,
  parameter int AW = mips16_pkg::AW
);
  import mips16_pkg::*;

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic [DW-1:0] id_imm;
  ctrl_t         id_ctrl;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;
  logic          flush;
  logic          exm_valid;
  logic          exm_reg_write;
  logic [AW-1:0] exm_rd;
  logic          wb_reg_write;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic          stall;
  logic          ex_valid;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [DW-1:0] ex_imm;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd;
  ctrl_t         ex_ctrl;
  logic [1:0]    ex_fwd_a;
  logic [1:0]    ex_fwd_b;
  logic [15:0]   stall_cnt;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_imm, id_ctrl,
    input  rf_rdata1, rf_rdata2, flush,
    input  exm_valid, exm_reg_write, exm_rd,
    input  wb_reg_write, wb_rd, wb_data,
    output stall, ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd,
    output ex_ctrl, ex_fwd_a, ex_fwd_b, stall_cnt
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_imm, id_ctrl,
    output rf_rdata1, rf_rdata2, flush,
    output exm_valid, exm_reg_write, exm_rd,
    output wb_reg_write, wb_rd, wb_data,
    input  stall, ex_valid, ex_a, ex_b, ex_imm, ex_rs, ex_rt, ex_rd,
    input  ex_ctrl, ex_fwd_a, ex_fwd_b, stall_cnt
  );

endinterface

// File: rtl/id_hazard_unit.sv
// Combinational source matching, forwarding selects and stall for the ID stage.
// ID_EX_FWD_EN: forwarding enabled, only load-use stalls; otherwise stall on any dependency.
module id_hazard_unit
  import mips16_pkg::*;
(
  input  logic          rst_n,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          idex_valid,
  input  logic          idex_reg_write,
  input  logic          idex_mem_read,
  input  logic [AW-1:0] idex_rd,
  input  logic          exm_valid,
  input  logic          exm_reg_write,
  input  logic [AW-1:0] exm_rd,
  output fwd_sel_t      fwd_a,
  output fwd_sel_t      fwd_b,
  output logic          stall
);

  logic rs_idex;
  logic rt_idex;
  logic rs_exm;
  logic rt_exm;
  logic load_use;
  logic stall_raw;

  always_comb begin
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    rs_idex   = src_match(id_rs, idex_valid, idex_reg_write, idex_rd);
    rt_idex   = src_match(id_rt, idex_valid, idex_reg_write, idex_rd);
    rs_exm    = src_match(id_rs, exm_valid, exm_reg_write, exm_rd);
    rt_exm    = src_match(id_rt, exm_valid, exm_reg_write, exm_rd);
    load_use  = id_valid && idex_mem_read && (rs_idex || rt_idex);
`ifdef ID_EX_FWD_EN
    // Nearest producer wins: ID/EX moves to EX/MEM as this instruction enters EX.
    fwd_a     = rs_idex ? FWD_EXM : (rs_exm ? FWD_WB : FWD_RF);
    fwd_b     = rt_idex ? FWD_EXM : (rt_exm ? FWD_WB : FWD_RF);
    stall_raw = load_use;
`else
    stall_raw = load_use || (id_valid && (rs_idex || rt_idex || rs_exm || rt_exm));
`endif
    stall     = stall_raw && !flush && rst_n;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through bypass, forwarding selects and interlock.
// ID_EX_FWD_EN selects the forwarding build; undefined falls back to stall-only.
module id_ex_stage #(
  parameter int DW = mips16_pkg::DW,
  parameter int AW = mips16_pkg::AW
)(
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);
  import mips16_pkg::*;

  logic          stall;
  logic          bubble;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  logic          ex_valid_q;
  logic [DW-1:0] ex_a_q;
  logic [DW-1:0] ex_b_q;
  logic [DW-1:0] ex_imm_q;
  logic [AW-1:0] ex_rs_q;
  logic [AW-1:0] ex_rt_q;
  logic [AW-1:0] ex_rd_q;
  ctrl_t         ex_ctrl_q;
  fwd_sel_t      ex_fwd_a_q;
  fwd_sel_t      ex_fwd_b_q;
  logic [15:0]   stall_cnt_q;

  id_hazard_unit u_hazard (
    .rst_n          (rst_n),
    .flush          (bus.flush),
    .id_valid       (bus.id_valid),
    .id_rs          (bus.id_rs),
    .id_rt          (bus.id_rt),
    .idex_valid     (ex_valid_q),
    .idex_reg_write (ex_ctrl_q.reg_write),
    .idex_mem_read  (ex_ctrl_q.mem_read),
    .idex_rd        (ex_rd_q),
    .exm_valid      (bus.exm_valid),
    .exm_reg_write  (bus.exm_reg_write),
    .exm_rd         (bus.exm_rd),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .stall          (stall)
  );

  // Same-cycle writeback has not reached the register file read port yet.
  always_comb begin
    op_a   = src_match(bus.id_rs, 1'b1, bus.wb_reg_write, bus.wb_rd) ? bus.wb_data : bus.rf_rdata1;
    op_b   = src_match(bus.id_rt, 1'b1, bus.wb_reg_write, bus.wb_rd) ? bus.wb_data : bus.rf_rdata2;
    bubble = bus.flush || stall || !bus.id_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      ex_fwd_a_q <= FWD_RF;
      ex_fwd_b_q <= FWD_RF;
    end else if (bubble) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else begin
      ex_valid_q <= 1'b1;
      ex_a_q     <= op_a;
      ex_b_q     <= op_b;
      ex_imm_q   <= bus.id_imm;
      ex_rs_q    <= bus.id_rs;
      ex_rt_q    <= bus.id_rt;
      ex_rd_q    <= bus.id_rd;
      ex_ctrl_q  <= bus.id_ctrl;
      ex_fwd_a_q <= fwd_a;
      ex_fwd_b_q <= fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall     = stall;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_a      = ex_a_q;
  assign bus.ex_b      = ex_b_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_rs     = ex_rs_q;
  assign bus.ex_rt     = ex_rt_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.ex_fwd_a  = ex_fwd_a_q;
  assign bus.ex_fwd_b  = ex_fwd_b_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage; expectations follow the ID_EX_FWD_EN setting.
module tb_id_ex_stage;

  localparam int ADD = 'h80;
  localparam int SUB = 'h81;
  localparam int ORR = 'h83;
  localparam int LW  = 'hD8;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_run = 0;
  int          n_fail = 0;
  logic [15:0] cnt_m;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [2:0]  rs, rt, rd;
    bit [7:0]  ctrl;
    bit [15:0] d1, d2;
    bit        fl;
    bit        xv;
    bit [2:0]  xrd;
    bit        wwe;
    bit [2:0]  wrd;
    bit [15:0] wd;
    bit        e_stall, e_valid;
    bit [15:0] ea, eb;
    bit [1:0]  fa, fb;
  } vec_t;

  vec_t tbl[$];
  vec_t idle_v;

  function automatic vec_t mk(input int v, rs, rt, rd, ctrl, d1, d2, fl, xv, xrd,
                              wwe, wrd, wd, es, ev, ea, eb, fa, fb);
    vec_t t;
    t.v = 1'(v);     t.rs = 3'(rs);   t.rt = 3'(rt);    t.rd = 3'(rd);
    t.ctrl = 8'(ctrl); t.d1 = 16'(d1); t.d2 = 16'(d2);  t.fl = 1'(fl);
    t.xv = 1'(xv);   t.xrd = 3'(xrd); t.wwe = 1'(wwe);  t.wrd = 3'(wrd);
    t.wd = 16'(wd);  t.e_stall = 1'(es); t.e_valid = 1'(ev);
    t.ea = 16'(ea);  t.eb = 16'(eb);  t.fa = 2'(fa);    t.fb = 2'(fb);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.id_valid      = t.v;
    bus.id_rs         = t.rs;
    bus.id_rt         = t.rt;
    bus.id_rd         = t.rd;
    bus.id_imm        = t.d1 ^ 16'hA5A5;
    bus.id_ctrl       = t.ctrl;
    bus.rf_rdata1     = t.d1;
    bus.rf_rdata2     = t.d2;
    bus.flush         = t.fl;
    bus.exm_valid     = t.xv;
    bus.exm_reg_write = t.xv;
    bus.exm_rd        = t.xrd;
    bus.wb_reg_write  = t.wwe;
    bus.wb_rd         = t.wrd;
    bus.wb_data       = t.wd;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    drive(t);
    #1;
    chk($sformatf("v%0d stall", idx), 32'(bus.stall), 32'(t.e_stall));
    if (t.e_stall && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d ex_valid", idx), 32'(bus.ex_valid), 32'(t.e_valid));
    chk($sformatf("v%0d stall_cnt", idx), 32'(bus.stall_cnt), 32'(cnt_m));
    if (t.e_valid) begin
      chk($sformatf("v%0d ex_a", idx), 32'(bus.ex_a), 32'(t.ea));
      chk($sformatf("v%0d ex_b", idx), 32'(bus.ex_b), 32'(t.eb));
      chk($sformatf("v%0d ex_imm", idx), 32'(bus.ex_imm), 32'(t.d1 ^ 16'hA5A5));
      chk($sformatf("v%0d ex_rd", idx), 32'(bus.ex_rd), 32'(t.rd));
      chk($sformatf("v%0d ex_rs_rt", idx), 32'({bus.ex_rs, bus.ex_rt}), 32'({t.rs, t.rt}));
      chk($sformatf("v%0d ex_ctrl", idx), 32'(bus.ex_ctrl), 32'(t.ctrl));
      chk($sformatf("v%0d ex_fwd_a", idx), 32'(bus.ex_fwd_a), 32'(t.fa));
      chk($sformatf("v%0d ex_fwd_b", idx), 32'(bus.ex_fwd_b), 32'(t.fb));
    end else begin
      chk($sformatf("v%0d bubble ctrl", idx), 32'(bus.ex_ctrl), 32'h0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ex_valid"}, 32'(bus.ex_valid), 32'h0);
    chk({tag, " ex_a_b"}, 32'({bus.ex_a, bus.ex_b}), 32'h0);
    chk({tag, " ex_imm"}, 32'(bus.ex_imm), 32'h0);
    chk({tag, " ex_idx"}, 32'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 32'h0);
    chk({tag, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'h0);
    chk({tag, " ex_fwd"}, 32'({bus.ex_fwd_a, bus.ex_fwd_b}), 32'h0);
    chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'h0);
  endtask

  initial begin
    // fields: v rs rt rd ctrl d1 d2 fl | xv xrd | wwe wrd wd | stall valid ea eb fa fb
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);

    // add r1,r2,r3 then sub r2,r1,r3 then or r4,r1,r1
    tbl.push_back(mk(1, 2, 3, 1, ADD, 'h2, 'h3, 0,  0, 0,  0, 0, 0,  0, 1, 'h2, 'h3, 0, 0));
`ifdef ID_EX_FWD_EN
    tbl.push_back(mk(1, 1, 3, 2, SUB, 'h11, 'h3, 0,  0, 0,  0, 0, 0,  0, 1, 'h11, 'h3, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4, ORR, 'h11, 'h11, 0,  1, 1,  0, 0, 0,  0, 1, 'h11, 'h11, 2, 2));
`else
    tbl.push_back(mk(1, 1, 3, 2, SUB, 'h11, 'h3, 0,  0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 2, SUB, 'h11, 'h3, 0,  1, 1,  0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 2, SUB, 'h11, 'h3, 0,  0, 0,  1, 1, 'h1234,  0, 1, 'h1234, 'h3, 0, 0));
`endif
    tbl.push_back(idle_v);

    // lw r5 then add r6,r5,r2
    tbl.push_back(mk(1, 1, 0, 5, LW, 'h100, 0, 0,  0, 0,  0, 0, 0,  0, 1, 'h100, 0, 0, 0));
`ifdef ID_EX_FWD_EN
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  1, 5,  0, 0, 0,  0, 1, 0, 'h22, 2, 0));
`else
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  1, 5,  0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  0, 0,  1, 5, 'h5555,  0, 1, 'h5555, 'h22, 0, 0));
`endif
    tbl.push_back(idle_v);

    // write-through on rs, then on rt
    tbl.push_back(mk(1, 3, 4, 7, ADD, 0, 'h44, 0,  0, 0,  1, 3, 'hBEEF,  0, 1, 'hBEEF, 'h44, 0, 0));
    tbl.push_back(mk(1, 2, 6, 1, ADD, 'h202, 'h606, 0,  0, 0,  1, 6, 'hCAFE,  0, 1, 'h202, 'hCAFE, 0, 0));

    // writer to r0, then reader of r0 with r0 producers everywhere
    tbl.push_back(mk(1, 2, 3, 0, ADD, 5, 6, 0,  0, 0,  0, 0, 0,  0, 1, 5, 6, 0, 0));
    tbl.push_back(mk(1, 0, 0, 3, ADD, 0, 0, 0,  1, 0,  1, 0, 'hDEAD,  0, 1, 0, 0, 0, 0));
    tbl.push_back(idle_v);

    // flush on top of a load-use
    tbl.push_back(mk(1, 1, 0, 5, LW, 'h100, 0, 0,  0, 0,  0, 0, 0,  0, 1, 'h100, 0, 0, 0));
    tbl.push_back(mk(1, 5, 2, 6, ADD, 0, 'h22, 1,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(idle_v);

`ifdef ID_EX_FWD_EN
    // both producers hold r1: the nearer one (ID/EX) must win
    tbl.push_back(mk(1, 2, 3, 1, ADD, 'h9, 'h8, 0,  0, 0,  0, 0, 0,  0, 1, 'h9, 'h8, 0, 0));
    tbl.push_back(mk(1, 1, 1, 5, SUB, 7, 7, 0,  1, 1,  0, 0, 0,  0, 1, 7, 7, 1, 1));
    tbl.push_back(idle_v);
`endif

    // reset: inputs set up so an unmasked stall would show
    cnt_m = 16'h0;
    rst_n = 1'b0;
    drive(mk(1, 1, 1, 2, ADD, 'h11, 'h22, 0,  1, 1,  1, 1, 'h33,  0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst stall", 32'(bus.stall), 32'h0);
    chk_all_zero("rst");
    drive(idle_v);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifndef ID_EX_FWD_EN
    // hold a dependency long enough to saturate the stall counter
    @(negedge clk);
    drive(mk(1, 1, 2, 3, ADD, 0, 0, 0,  1, 1,  0, 0, 0,  0, 0, 0, 0, 0, 0));
    repeat (65600) @(posedge clk);
    #1;
    chk("sat stall_cnt", 32'(bus.stall_cnt), 32'hFFFF);
    chk("sat stall", 32'(bus.stall), 32'h1);
    chk("sat ex_valid", 32'(bus.ex_valid), 32'h0);
    cnt_m = 16'hFFFF;
`endif

    // reset arriving during a load-use stall
    apply(idle_v, 900);
    apply(mk(1, 1, 0, 5, LW, 'h100, 0, 0,  0, 0,  0, 0, 0,  0, 1, 'h100, 0, 0, 0), 901);
    @(negedge clk);
    drive(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("midrst stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    rst_n = 1'b1;
    cnt_m = 16'h0;
    apply(mk(1, 5, 2, 6, ADD, 0, 'h22, 0,  0, 0,  0, 0, 0,  0, 1, 0, 'h22, 0, 0), 902);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
